fop_sweep: RTL and testbench

FOP_SWEEP -- requirements
Module: fop_sweep

---
 rtl/fop_sweep.sv | 89 ++++++++
 tb/tb_fop_sweep.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fop_sweep.sv
// Truth-table sweeper: steps a code through 0..2**n-1 into an external
// function block, capturing its output into tt and counting the ones seen.
module fop_sweep #(
  parameter int n = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [n-1:0]      code,
  input  logic              f,
  output logic              busy,
  output logic              done,
  output logic [2**n-1:0]   tt,
  output logic [n:0]        ones,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [n-1:0] LAST_CODE = '1;

  state_t            r_state;
  logic [n-1:0]      r_code;
  logic              r_busy;
  logic              r_done;
  logic [2**n-1:0]   r_tt;
  logic [n:0]        r_ones;
  logic [n:0]        w_f_ext;

  assign w_f_ext = {{n{1'b0}}, f};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SWEEP;
            r_busy  <= 1'b1;
            r_code  <= '0;
            r_tt    <= '0;
            r_ones  <= '0;
          end
        end
        S_SWEEP: begin
          // f is combinational on the code presented this cycle
          r_tt[r_code] <= f;
          r_ones       <= r_ones + w_f_ext;
          if (r_code == LAST_CODE) begin
            r_code  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_code <= r_code + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_code  <= '0;
        end
      endcase
    end
  end

  assign code        = r_code;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tt          = r_tt;
  assign ones        = r_ones;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fop_sweep.sv
// Bench for fop_sweep: a truth-table model drives f, sweeps push expected
// results, and a negedge monitor pops and compares on each done pulse.
module tb_fop_sweep;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  code;
  logic        f;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic [4:0]  ones;
  logic [1:0]  dbg_state;

  logic [15:0] func_tt;
  int          cyc;
  int          n_vec;
  int          n_err;
  int          exp_idx;
  bit          mon_en;

  logic [15:0] exp_tt_q[$];
  logic [4:0]  exp_ones_q[$];
  int          exp_cyc_q[$];

  fop_sweep #(.n(4)) dut (
    .clk(clk), .rst(rst), .start(start), .code(code), .f(f),
    .busy(busy), .done(done), .tt(tt), .ones(ones), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // downstream function block model
  always_comb f = func_tt[code];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        check("code_seq", {28'd0, code}, exp_idx);
        exp_idx++;
      end else begin
        exp_idx = 0;
      end
      if (done === 1'b1) begin
        if (exp_cyc_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          check("done_cycle", cyc, exp_cyc_q.pop_front());
          check("tt", {16'd0, tt}, {16'd0, exp_tt_q.pop_front()});
          check("ones", {27'd0, ones}, {27'd0, exp_ones_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic start_sweep(input logic [15:0] e_tt, input logic [4:0] e_ones);
    @(negedge clk);
    exp_tt_q.push_back(e_tt);
    exp_ones_q.push_back(e_ones);
    exp_cyc_q.push_back(cyc + 17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (exp_cyc_q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (exp_cyc_q.size() != 0) begin
      check("drain_timeout", exp_cyc_q.size(), 32'd0);
      exp_cyc_q.delete();
      exp_tt_q.delete();
      exp_ones_q.delete();
    end
  endtask

  task automatic wait_code(input logic [3:0] v);
    int k;
    k = 0;
    while (!(busy === 1'b1 && code == v) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!(busy === 1'b1 && code == v)) check("wait_code_timeout", {28'd0, code}, {28'd0, v});
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_idx = 0; mon_en = 0;
    rst = 1'b1; start = 1'b0; func_tt = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_code", {28'd0, code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tt", {16'd0, tt}, 32'd0);
    check("rst_ones", {27'd0, ones}, 32'd0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // minterms {0,1,2,3,5,7,8,11,13}
    func_tt = 16'h29AF;
    start_sweep(16'h29AF, 5'd9);
    wait_drain(40);

    func_tt = 16'h0000;
    start_sweep(16'h0000, 5'd0);
    wait_drain(40);

    func_tt = 16'hFFFF;
    start_sweep(16'hFFFF, 5'b10000);
    wait_drain(40);

    // idle hold: results stable, no done
    repeat (10) begin
      @(negedge clk);
      check("idle_tt", {16'd0, tt}, 32'h0000FFFF);
      check("idle_ones", {27'd0, ones}, 32'd16);
      check("idle_done", {31'd0, done}, 32'd0);
    end

    // start mid-sweep is ignored
    func_tt = 16'h29AF;
    start_sweep(16'h29AF, 5'd9);
    wait_code(4'd4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (25) @(negedge clk);

    // start held 40 cycles: three sweeps, done every 18 cycles
    func_tt = 16'h1234;
    @(negedge clk);
    exp_tt_q.push_back(16'h1234); exp_ones_q.push_back(5'd5); exp_cyc_q.push_back(cyc + 17);
    exp_tt_q.push_back(16'h1234); exp_ones_q.push_back(5'd5); exp_cyc_q.push_back(cyc + 35);
    exp_tt_q.push_back(16'h1234); exp_ones_q.push_back(5'd5); exp_cyc_q.push_back(cyc + 53);
    start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (3) @(negedge clk);

    // reset at code 7 aborts the sweep
    func_tt = 16'h29AF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_code(4'd7);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_code", {28'd0, code}, 32'd0);
    check("abort_tt", {16'd0, tt}, 32'd0);
    check("abort_ones", {27'd0, ones}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", {31'd0, busy}, 32'd0);

    // first start after reset honoured
    func_tt = 16'h8001;
    start_sweep(16'h8001, 5'd2);
    wait_drain(40);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
